// File: rtl/page_buf_pkg.sv
// -----------------------------------------------------------------------------
// page_buf_pkg
// Shared definitions for the page buffer sequencer: page geometry, the
// command opcodes and the sequencer state encoding.
// -----------------------------------------------------------------------------
package page_buf_pkg;

    // Page geometry
    localparam int PAGE_BYTES = 512;
    localparam int PAGE_AW    = 9;   // log2(PAGE_BYTES)
    localparam int PAGE_DW    = 8;

    // Command opcodes (cmd_op)
    localparam logic OP_FILL  = 1'b0;  // stream -> buffer
    localparam logic OP_DRAIN = 1'b1;  // buffer -> stream

    // Sequencer state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FILL  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage : page_buf_pkg

// File: rtl/page_buf_dec.sv
// -----------------------------------------------------------------------------
// page_buf_dec
// Address to one-hot write-enable decoder for the page buffer. With en low
// every output bit is zero; with en high exactly the bit selected by addr
// is set.
//
// Ports:
//   en      in   1      decode enable (a write handshake is happening)
//   addr    in   AW     byte column to enable
//   onehot  out  DEPTH  per-byte write enables
// -----------------------------------------------------------------------------
module page_buf_dec #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic             en,
    input  logic [AW-1:0]    addr,
    output logic [DEPTH-1:0] onehot
);

    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment, otherwise a latch is inferred.
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule : page_buf_dec

// File: rtl/page_buf_seq.sv
// -----------------------------------------------------------------------------
// page_buf_seq
// Sequencer between the host/flash byte streams and the 512-byte page
// buffer. A FILL command writes cmd_len bytes from the wr_* stream into
// consecutive buffer columns starting at cmd_col; a DRAIN command reads
// cmd_len bytes from the buffer onto the rd_* stream through a one-deep
// output register. Columns wrap DEPTH-1 -> 0. done pulses for one cycle
// when a command completes.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_op                    OP_FILL / OP_DRAIN
//   cmd_col                   start column
//   cmd_len                   byte count, 0 = none, >DEPTH clamps to DEPTH
//   wr_valid/wr_ready/wr_data fill stream (sink)
//   rd_valid/rd_ready/rd_data drain stream (source)
//   mem_din                   buffer write data (wr_data passed through)
//   mem_en                    buffer per-byte write enables (one-hot or 0)
//   mem_sel                   buffer read select (current column)
//   mem_dout                  buffer read data
//   busy                      high whenever not IDLE
//   done                      one-cycle completion pulse
// -----------------------------------------------------------------------------
module page_buf_seq
    import page_buf_pkg::*;
#(
    parameter int DEPTH = page_buf_pkg::PAGE_BYTES,
    parameter int AW    = page_buf_pkg::PAGE_AW,
    parameter int DW    = page_buf_pkg::PAGE_DW
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [AW-1:0]    cmd_col,
    input  logic [AW:0]      cmd_len,

    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [DW-1:0]    wr_data,

    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [DW-1:0]    rd_data,

    output logic [DW-1:0]    mem_din,
    output logic [DEPTH-1:0] mem_en,
    output logic [AW-1:0]    mem_sel,
    input  logic [DW-1:0]    mem_dout,

    output logic             busy,
    output logic             done
);

    localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q,   ptr_d;
    logic [AW:0]     cnt_q,   cnt_d;
    logic            rd_valid_q, rd_valid_d;
    logic [DW-1:0]   rd_data_q,  rd_data_d;

    logic [AW:0]     len_clamped;
    logic            fill_fire;
    logic            drain_load;
    logic            out_free;

    assign len_clamped = (cmd_len > DEPTH_LEN) ? DEPTH_LEN : cmd_len;

    // The output register can take a new byte when it is empty or its
    // current byte is being consumed this cycle.
    assign out_free   = !rd_valid_q || rd_ready;

    assign cmd_ready  = (state_q == ST_IDLE);
    assign wr_ready   = (state_q == ST_FILL) && (cnt_q != '0);
    assign fill_fire  = wr_valid && wr_ready;
    assign drain_load = (state_q == ST_DRAIN) && (cnt_q != '0) && out_free;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    ptr_d = cmd_col;
                    cnt_d = len_clamped;
                    // The opcode is held by the state itself: FILL and
                    // DRAIN are separate states for the whole transfer.
                    if (len_clamped == '0) begin
                        state_d = ST_DONE;
                    end else if (cmd_op == OP_DRAIN) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end

            ST_FILL: begin
                if (fill_fire) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == (AW+1)'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DRAIN: begin
                if (drain_load) begin
                    rd_data_d  = mem_dout;
                    rd_valid_d = 1'b1;
                    ptr_d      = ptr_q + 1'b1;
                    cnt_d      = cnt_q - 1'b1;
                end else if (rd_ready) begin
                    rd_valid_d = 1'b0;
                end
                // Finish only once the last byte has left the output stage.
                if ((cnt_q == '0) && out_free) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    page_buf_dec #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dec (
        .en     (fill_fire),
        .addr   (ptr_q),
        .onehot (mem_en)
    );

    assign mem_din  = wr_data;
    assign mem_sel  = ptr_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

endmodule : page_buf_seq

// File: tb/tb_page_buf_seq.sv
// -----------------------------------------------------------------------------
// tb_page_buf_seq
// Self-checking bench for page_buf_seq. Contains a byte-array model of the
// page buffer the DUT drives, a transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, and a
// randomized command loop.
// -----------------------------------------------------------------------------
module tb_page_buf_seq;

    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int DW    = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic [AW-1:0]    cmd_col;
    logic [AW:0]      cmd_len;
    logic             wr_valid;
    logic             wr_ready;
    logic [DW-1:0]    wr_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [DW-1:0]    rd_data;
    logic [DW-1:0]    mem_din;
    logic [DEPTH-1:0] mem_en;
    logic [AW-1:0]    mem_sel;
    logic [DW-1:0]    mem_dout;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    page_buf_seq #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_col   (cmd_col),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .mem_din   (mem_din),
        .mem_en    (mem_en),
        .mem_sel   (mem_sel),
        .mem_dout  (mem_dout),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- page buffer attached to the DUT ----------------------
    // Write requests are captured mid-cycle so the update at the edge does
    // not race the DUT's own flops.
    logic [DW-1:0]    env_buf [DEPTH];
    logic [DEPTH-1:0] en_cap  = '0;
    logic [DW-1:0]    din_cap = '0;

    always @(negedge clk) begin
        #3;
        en_cap  = mem_en;
        din_cap = mem_din;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) env_buf[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) if (en_cap[i]) env_buf[i] <= din_cap;
        end
    end

    assign mem_dout = env_buf[mem_sel];

    // ---------------- transaction-level reference model --------------------
    typedef enum {M_IDLE, M_FILL, M_DRAIN, M_DONE} mphase_t;
    mphase_t          ph = M_IDLE;
    int               m_col, m_len, m_idx;
    logic [7:0]       exp_page [DEPTH];
    logic             prev_stall = 1'b0;
    logic [7:0]       prev_data  = '0;
    logic [DEPTH-1:0] exp_en;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            check("rst_busy",     busy,     1'b0);
            check("rst_done",     done,     1'b0);
            check("rst_rd_valid", rd_valid, 1'b0);
            check("rst_mem_en",   mem_en,   '0);
            check("rst_cmd_rdy",  cmd_ready, 1'b1);
            ph = M_IDLE;
            prev_stall = 1'b0;
            for (int i = 0; i < DEPTH; i++) exp_page[i] = 8'h00;
        end else begin
            check("busy",      busy,      ph != M_IDLE);
            check("cmd_ready", cmd_ready, ph == M_IDLE);
            check("done",      done,      ph == M_DONE);
            check("wr_ready",  wr_ready,  ph == M_FILL);
            check("mem_din",   mem_din,   wr_data);
            exp_en = '0;
            if (ph == M_FILL && wr_valid) exp_en[(m_col + m_idx) % DEPTH] = 1'b1;
            check("mem_en", mem_en, exp_en);
            if (ph != M_DRAIN) check("rd_valid_outside_drain", rd_valid, 1'b0);
            if (prev_stall) begin
                check("rd_valid_hold", rd_valid, 1'b1);
                check("rd_data_hold",  rd_data,  prev_data);
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;

            case (ph)
                M_IDLE: if (cmd_valid) begin
                    m_col = int'(cmd_col);
                    m_len = (int'(cmd_len) > DEPTH) ? DEPTH : int'(cmd_len);
                    m_idx = 0;
                    if (m_len == 0)  ph = M_DONE;
                    else if (cmd_op) ph = M_DRAIN;
                    else             ph = M_FILL;
                end
                M_FILL: if (wr_valid) begin
                    exp_page[(m_col + m_idx) % DEPTH] = wr_data;
                    m_idx++;
                    if (m_idx == m_len) ph = M_DONE;
                end
                M_DRAIN: if (rd_valid && rd_ready) begin
                    check("rd_data", rd_data, exp_page[(m_col + m_idx) % DEPTH]);
                    m_idx++;
                    if (m_idx == m_len) ph = M_DONE;
                end
                M_DONE: ph = M_IDLE;
                default: ph = M_IDLE;
            endcase
        end
    end

    // ---------------- command driver ----------------------------------------
    logic [7:0] rx_q [$];

    // rd_mode: 0 = always ready, 1 = random, 2 = pattern 1,0,0,1,0,0...
    task automatic run_cmd(input logic op, input int col, input int len,
                           input int wr_pct, input int rd_mode,
                           input logic [7:0] dbase, input int abort_after,
                           output int done_cyc, output int first_rv,
                           output int n_wr, output int n_rd);
        int cyc;
        bit fin;
        done_cyc = -1;
        first_rv = -1;
        n_wr     = 0;
        n_rd     = 0;
        rx_q.delete();
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_col   = 9'(col);
        cmd_len   = 10'(len);
        #1;
        check("cmd_ready_at_issue", cmd_ready, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 1'($urandom);
        cmd_col   = 9'($urandom);
        cmd_len   = 10'($urandom);
        cyc = 1;
        fin = 1'b0;
        while (!fin && cyc < 4000) begin
            if (abort_after >= 0 && n_wr == abort_after) begin
                rst      = 1'b1;
                wr_valid = 1'b0;
                #1;
                check("abort_busy",      busy,      1'b0);
                check("abort_mem_en",    mem_en,    '0);
                check("abort_done",      done,      1'b0);
                check("abort_cmd_ready", cmd_ready, 1'b1);
                @(negedge clk);
                rst = 1'b0;
                #1;
                check("abort_cmd_ready_next", cmd_ready, 1'b1);
                check("abort_no_done",        done,      1'b0);
                check("abort_buf_cleared",    env_buf[col % DEPTH], 8'h00);
                rd_ready = 1'b0;
                return;
            end
            wr_valid = ($urandom_range(99) < wr_pct);
            wr_data  = wr_valid ? dbase + 8'(n_wr) : 8'($urandom);
            case (rd_mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = 1'($urandom_range(1));
                default: rd_ready = ((cyc % 3) == 2);
            endcase
            #1;
            if (wr_valid && wr_ready) n_wr++;
            if (rd_valid && first_rv < 0) first_rv = cyc;
            if (rd_valid && rd_ready) begin
                n_rd++;
                rx_q.push_back(rd_data);
            end
            if (done) begin
                done_cyc = cyc;
                fin = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        check("cmd_completed_in_budget", fin, 1'b1);
    endtask

    // ---------------- stimulus ---------------------------------------------
    initial begin
        int dc, frv, nw, nr, errs, lenc, len;
        logic op;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_col   = '0;
        cmd_len   = '0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("reset_busy",      busy,      1'b0);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_rd_valid",  rd_valid,  1'b0);
        check("reset_rd_data",   rd_data,   8'h00);
        check("reset_mem_en",    mem_en,    '0);
        check("reset_mem_sel",   mem_sel,   9'd0);
        check("reset_done",      done,      1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Full-page fill, bytes k & FF.
        run_cmd(1'b0, 0, 512, 100, 0, 8'h00, -1, dc, frv, nw, nr);
        check("fill512_done_cyc", dc, 513);
        check("fill512_bytes",    nw, 512);
        errs = 0;
        for (int k = 0; k < DEPTH; k++) if (env_buf[k] !== 8'(k)) errs++;
        check("fill512_buffer_errs", errs, 0);

        // Full-page drain at full rate.
        run_cmd(1'b1, 0, 512, 0, 0, 8'h00, -1, dc, frv, nw, nr);
        check("drain512_first_rv", frv, 2);
        check("drain512_done_cyc", dc, 514);
        check("drain512_bytes",    nr, 512);
        errs = 0;
        for (int k = 0; k < rx_q.size(); k++) if (rx_q[k] !== 8'(k)) errs++;
        check("drain512_data_errs", errs, 0);

        // Wrap-around fill and drain.
        run_cmd(1'b0, 510, 4, 100, 0, 8'hA0, -1, dc, frv, nw, nr);
        check("wrapfill_done_cyc", dc, 5);
        check("wrapfill_buf510", env_buf[510], 8'hA0);
        check("wrapfill_buf511", env_buf[511], 8'hA1);
        check("wrapfill_buf0",   env_buf[0],   8'hA2);
        check("wrapfill_buf1",   env_buf[1],   8'hA3);
        run_cmd(1'b1, 510, 4, 0, 0, 8'h00, -1, dc, frv, nw, nr);
        check("wrapdrain_done_cyc", dc, 6);
        check("wrapdrain_count", rx_q.size(), 4);
        if (rx_q.size() == 4) begin
            check("wrapdrain_b0", rx_q[0], 8'hA0);
            check("wrapdrain_b1", rx_q[1], 8'hA1);
            check("wrapdrain_b2", rx_q[2], 8'hA2);
            check("wrapdrain_b3", rx_q[3], 8'hA3);
        end

        // Drain with back-pressure: columns 2..9 still hold 02..09.
        run_cmd(1'b1, 2, 8, 0, 2, 8'h00, -1, dc, frv, nw, nr);
        check("stall_drain_count", nr, 8);
        errs = 0;
        for (int k = 0; k < rx_q.size(); k++) if (rx_q[k] !== 8'(k + 2)) errs++;
        check("stall_drain_data_errs", errs, 0);

        // Zero-length commands.
        run_cmd(1'b0, 7, 0, 100, 0, 8'h11, -1, dc, frv, nw, nr);
        check("len0_fill_done_cyc", dc, 1);
        check("len0_fill_bytes",    nw, 0);
        run_cmd(1'b1, 7, 0, 0, 0, 8'h00, -1, dc, frv, nw, nr);
        check("len0_drain_done_cyc", dc, 1);
        check("len0_drain_bytes",    nr, 0);

        // Oversized length clamps to one full page (wraps back to col 99).
        run_cmd(1'b0, 100, 700, 100, 0, 8'h37, -1, dc, frv, nw, nr);
        check("len700_done_cyc", dc, 513);
        check("len700_bytes",    nw, 512);
        check("len700_first",    env_buf[100], 8'h37);
        check("len700_last",     env_buf[99],  8'h36);

        // Reset in the middle of a fill, after three bytes.
        run_cmd(1'b0, 20, 10, 100, 0, 8'h55, 3, dc, frv, nw, nr);
        check("abort_bytes_before_rst", nw, 3);

        // Randomized commands.
        for (int t = 0; t < 40; t++) begin
            op = 1'($urandom);
            case ($urandom_range(9))
                0:       len = 0;
                1:       len = int'($urandom_range(1023));
                default: len = int'($urandom_range(40, 1));
            endcase
            lenc = (len > DEPTH) ? DEPTH : len;
            run_cmd(op, int'($urandom_range(DEPTH - 1)), len,
                    int'($urandom_range(100, 30)), int'($urandom_range(1)),
                    8'($urandom), -1, dc, frv, nw, nr);
            if (op) check("rand_drain_count", nr, lenc);
            else    check("rand_fill_count",  nw, lenc);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_page_buf_seq

// File: doc/page_buf_seq.md
# page_buf_seq

Sequencer for the 512-byte page buffer (per-byte write enables, combinational read select). It accepts fill/drain commands and converts a byte stream with a valid/ready handshake into the buffer's one-hot write enables and read select. It sits between the host/flash data paths and the page buffer. It owns column addressing, length counting, wrap-around and completion signalling.

## Interface
Parameters:
- DEPTH, 512, page buffer bytes (power of two)
- AW, 9, buffer address width (log2 DEPTH)
- DW, 8, data width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid (IDLE only)
- cmd_op  in  1  0 = FILL (stream into buffer), 1 = DRAIN (buffer to stream)
- cmd_col  in  AW  start column
- cmd_len  in  AW+1  byte count; 0 = no transfer; values >DEPTH clamp to DEPTH
- wr_valid / wr_ready / wr_data  in / out / in  1 / 1 / DW  fill stream
- rd_valid / rd_ready / rd_data  out / in / out  1 / 1 / DW  drain stream
- mem_din  out  DW  buffer Data_in (= wr_data)
- mem_en  out  DEPTH  buffer per-byte write enables
- mem_sel  out  AW  buffer read select (= ptr)
- mem_dout  in  DW  buffer Data_out
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, FILL, DRAIN, DONE. Encoding lives in the package.
- IDLE: cmd_ready=1. On handshake: ptr<=cmd_col, cnt<=clamp(cmd_len). If cnt would be 0, go to DONE. Otherwise go to FILL or DRAIN per cmd_op. cmd_op is latched.
- FILL: wr_ready = (cnt!=0).
  - On wr_valid&&wr_ready: mem_en = onehot(ptr), else all zero.
  - ptr<=ptr+1 (mod DEPTH), cnt<=cnt-1.
  - On the handshake that takes cnt to 0, go to DONE.
- DRAIN: 1-deep registered output stage.
  - load = (cnt!=0) && (!rd_valid || rd_ready).
  - On load: rd_data<=mem_dout, rd_valid<=1, ptr++, cnt--.
  - On rd_ready without load: rd_valid<=0.
  - When cnt==0 and (rd_valid==0, or rd_valid&&rd_ready this cycle), go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. cmd_ready=0.
- Address wrap: ptr is AW bits and wraps DEPTH-1→0 naturally. Example: col=510, len=4 touches 510, 511, 0, 1.
- mem_en is never non-zero outside a FILL handshake. At most one bit is set.
- Drain never reads past cnt. The byte at ptr is read only in the load cycle.

## Timing
- Reset values: state=IDLE, ptr=0, cnt=0, rd_valid=0, rd_data=0, done=0, mem_en=0, mem_sel=0, busy=0.
- Command accepted at edge E0. FILL/DRAIN is active from the cycle after E0.
- FILL: a byte accepted at edge Ek is stored in the buffer at the same edge. It is readable via mem_sel in the next cycle. Throughput is 1 byte/cycle.
- DRAIN: the first rd_valid rises one cycle after entering DRAIN, i.e. 2 cycles after E0. With rd_ready held high, throughput is 1 byte/cycle.
- rd_data/rd_valid are stable while rd_valid && !rd_ready.
- done pulses in the cycle after the final byte handshake. For len=0, done pulses in the cycle after E0. The next command can be accepted 1 cycle after done.
- A fill followed immediately by a drain of the same column returns the newly written data. There is no hazard, because the write commits before DRAIN starts.
- rst mid-transfer: return to IDLE immediately. No done pulse. A partial rd_data is discarded. The buffer is cleared by the same rst.

## Structure
- Package page_buf_pkg: state enum, OP_FILL/OP_DRAIN constants, PAGE_BYTES=512, AW=9, DW=8.
- Sub-module page_buf_dec: AW→DEPTH one-hot decoder with enable, producing mem_en.
- Top: FSM, ptr/cnt registers, drain output register.

## Test plan
- Reset, then FILL col=0 len=512 with bytes i&8'hFF, wr_valid always high → 512 consecutive single-bit mem_en; done pulses 513 cycles after E0; buffer[k]=k&FF.
- DRAIN col=0 len=512, rd_ready=1 → first rd_valid at E0+2; 512 bytes 00,01,…,FF,00,… with no gaps; done follows the last byte.
- FILL col=510 len=4, data A0..A3 → buffer[510]=A0, [511]=A1, [0]=A2, [1]=A3; DRAIN col=510 len=4 returns A0..A3.
- DRAIN len=8 with rd_ready toggling 1,0,0,1… → rd_data held stable while stalled; no byte lost or duplicated; done only after the 8th handshake.
- cmd_len=0 → done at E0+1, mem_en never set; cmd_len=700 → exactly 512 bytes transferred.
- Assert rst during FILL after 3 bytes → busy=0, mem_en=0, no done, cmd_ready=1 next cycle; a new command then runs normally.
